// File: rtl/fir_mac_sequencer.sv
`timescale 1ns/1ps
// fir_mac_sequencer: control FSM for the 33-tap, 4-bank SPSRAM FIR datapath.
// Define FIR_SEQ_OVERRUN_EN to build the sticky sample-overrun detector.
module fir_mac_sequencer #(
  parameter int TAPS_PER_BANK  = 10,
  parameter int LAST_BANK_TAPS = 3,
  parameter int RAM_RD_LAT     = 1,
  parameter int MUL_LAT        = 1
) (
  input  logic       iClk12M,
  input  logic       iRsn,
  input  logic       iEnSample600k,
  input  logic       iCoeffUpdateFlag,
  input  logic       iCsnRam,
  input  logic       iWrnRam,
  input  logic [5:0] iAddrRam,
  output logic [3:0] oCsnRam,
  output logic       oWrnRam,
  output logic [3:0] oAddrRam,
  output logic       oEnDelay,
  output logic       oAccClr,
  output logic [3:0] oEnMul,
  output logic [3:0] oEnAcc,
  output logic       oEnSum,
  output logic       oEnOut,
  output logic       oBusy,
  output logic       oAddrErr,
  output logic       oOverrun
);

  localparam int         PIPE_LEN    = RAM_RD_LAT + MUL_LAT;
  localparam logic [3:0] TAPS_4      = 4'(TAPS_PER_BANK);
  localparam logic [3:0] LAST_TAPS_4 = 4'(LAST_BANK_TAPS);
  localparam logic [3:0] LAST_ADDR   = 4'(TAPS_PER_BANK - 1);
  localparam logic [3:0] DRAIN_LAST  = 4'(PIPE_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_UPDATE, ST_WAIT, ST_SHIFT, ST_READ, ST_DRAIN, ST_SUM, ST_OUT
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       addr_err_q, addr_err_d;
  logic [3:0] pipe_q [PIPE_LEN];
  logic [3:0] pipe_d [PIPE_LEN];
  logic [3:0] rd_en;
  logic [3:0] bank_sel;
  logic       slot_bad;

  assign bank_sel = 4'b0001 << iAddrRam[5:4];
  assign slot_bad = (iAddrRam[3:0] >= TAPS_4) ||
                    ((iAddrRam[5:4] == 2'd3) && (iAddrRam[3:0] >= LAST_TAPS_4));

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_err_d = addr_err_q;
    rd_en      = 4'h0;
    oCsnRam    = 4'hF;
    oWrnRam    = 1'b1;
    oAddrRam   = 4'h0;
    oEnDelay   = 1'b0;
    oAccClr    = 1'b0;
    oEnSum     = 1'b0;
    oEnOut     = 1'b0;
    oBusy      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iCoeffUpdateFlag) begin
          state_d    = ST_UPDATE;
          addr_err_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_UPDATE: begin
        oWrnRam  = iWrnRam;
        oAddrRam = iAddrRam[3:0];
        if (!slot_bad) begin
          oCsnRam = ~bank_sel | {4{iCsnRam}};
        end else if (!iCsnRam && !iWrnRam) begin
          addr_err_d = 1'b1;
        end
        if (!iCoeffUpdateFlag) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (iCoeffUpdateFlag) begin
          state_d    = ST_UPDATE;
          addr_err_d = 1'b0;
        end else if (iEnSample600k) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        oBusy    = 1'b1;
        oEnDelay = 1'b1;
        oAccClr  = 1'b1;
        cnt_d    = 4'h0;
        state_d  = ST_READ;
      end
      ST_READ: begin
        oBusy    = 1'b1;
        oAddrRam = cnt_q;
        // Bank 3 holds only the last few taps; its upper slots stay deselected.
        rd_en    = {cnt_q < LAST_TAPS_4, 3'b111};
        oCsnRam  = ~rd_en;
        if (cnt_q == LAST_ADDR) begin
          cnt_d   = 4'h0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 4'h1;
        end
      end
      ST_DRAIN: begin
        oBusy = 1'b1;
        if (cnt_q == DRAIN_LAST) begin
          cnt_d   = 4'h0;
          state_d = ST_SUM;
        end else begin
          cnt_d = cnt_q + 4'h1;
        end
      end
      ST_SUM: begin
        oBusy   = 1'b1;
        oEnSum  = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        oBusy  = 1'b1;
        oEnOut = 1'b1;
        if (iCoeffUpdateFlag) begin
          state_d    = ST_UPDATE;
          addr_err_d = 1'b0;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read-enable delay line: tap RAM_RD_LAT-1 feeds the multipliers, the last tap the accumulators.
  always_comb begin
    pipe_d[0] = rd_en;
    for (int i = 1; i < PIPE_LEN; i++) pipe_d[i] = pipe_q[i-1];
  end

  assign oEnMul   = pipe_q[RAM_RD_LAT-1];
  assign oEnAcc   = pipe_q[PIPE_LEN-1];
  assign oAddrErr = addr_err_q;

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q    <= ST_IDLE;
      cnt_q      <= 4'h0;
      addr_err_q <= 1'b0;
      // NOTE: this small array drives enables directly, so it is reset rather than left unknown.
      for (int i = 0; i < PIPE_LEN; i++) pipe_q[i] <= 4'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_err_q <= addr_err_d;
      for (int i = 0; i < PIPE_LEN; i++) pipe_q[i] <= pipe_d[i];
    end
  end

`ifdef FIR_SEQ_OVERRUN_EN
  logic overrun_q, overrun_d;

  assign overrun_d = overrun_q | (oBusy & iEnSample600k);

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) overrun_q <= 1'b0;
    else       overrun_q <= overrun_d;
  end

  assign oOverrun = overrun_q;
`else
  assign oOverrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_sequencer.sv
`timescale 1ns/1ps
// Directed self-checking bench for fir_mac_sequencer: reset, filter timeline,
// coefficient update routing, overrun, mid-sequence flag and mid-sequence reset.
module tb_fir_mac_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       strobe = 1'b0;
  logic       flag = 1'b0;
  logic       csn_in = 1'b1;
  logic       wrn_in = 1'b1;
  logic [5:0] addr_in = 6'h00;

  logic [3:0] csn_o, addr_o, en_mul, en_acc;
  logic       wrn_o, en_delay, acc_clr, en_sum, en_out, busy, addr_err, overrun;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef FIR_SEQ_OVERRUN_EN
  localparam logic EXP_OVR = 1'b1;
`else
  localparam logic EXP_OVR = 1'b0;
`endif

  localparam logic [21:0] IDLE_VEC = {4'hF, 1'b1, 4'h0, 13'b0};

  fir_mac_sequencer dut (
    .iClk12M         (clk),
    .iRsn            (rst_n),
    .iEnSample600k   (strobe),
    .iCoeffUpdateFlag(flag),
    .iCsnRam         (csn_in),
    .iWrnRam         (wrn_in),
    .iAddrRam        (addr_in),
    .oCsnRam         (csn_o),
    .oWrnRam         (wrn_o),
    .oAddrRam        (addr_o),
    .oEnDelay        (en_delay),
    .oAccClr         (acc_clr),
    .oEnMul          (en_mul),
    .oEnAcc          (en_acc),
    .oEnSum          (en_sum),
    .oEnOut          (en_out),
    .oBusy           (busy),
    .oAddrErr        (addr_err),
    .oOverrun        (overrun)
  );

  always #5 clk = ~clk;

  wire [21:0] obs = {csn_o, wrn_o, addr_o, en_delay, acc_clr, en_mul, en_acc,
                     en_sum, en_out, busy};

  // Expected outputs k cycles after the edge that sampled the strobe.
  function automatic logic [21:0] exp_vec(input int k);
    logic [3:0] csn, addr, mul, acc;
    csn  = 4'hF;
    addr = 4'h0;
    mul  = 4'h0;
    acc  = 4'h0;
    if (k >= 2 && k <= 11) begin
      addr = 4'(k - 2);
      csn  = {(k - 2) >= 3, 3'b000};
    end
    if (k >= 3 && k <= 12) mul = {k <= 5, 3'b111};
    if (k >= 4 && k <= 13) acc = {k <= 6, 3'b111};
    return {csn, 1'b1, addr, k == 1, k == 1, mul, acc, k == 14, k == 15,
            k >= 1 && k <= 15};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq;
    strobe = 1'b1;
    tick();
    strobe = 1'b0;
  endtask

  task automatic run_seq(input string name);
    start_seq();
    for (int k = 1; k <= 19; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs !== exp_vec(k))
        $display("FAIL %s k=%0d outputs=%h expected=%h", name, k, obs, exp_vec(k));
      else n_pass++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_checks++;
    if (obs !== IDLE_VEC || addr_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_async outputs=%h err=%b ovr=%b expected=%h 0 0",
               obs, addr_err, overrun, IDLE_VEC);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (obs !== IDLE_VEC || addr_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_held outputs=%h err=%b ovr=%b expected=%h 0 0",
               obs, addr_err, overrun, IDLE_VEC);
    else n_pass++;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (obs !== IDLE_VEC)
      $display("FAIL reset_wait outputs=%h expected=%h", obs, IDLE_VEC);
    else n_pass++;
  endtask

  task automatic test_filter;
    run_seq("filter_a");
    run_seq("filter_b");
  endtask

  task automatic test_update;
    flag = 1'b1;
    tick();
    for (int b = 0; b < 4; b++) begin
      for (int s = 0; s < ((b == 3) ? 3 : 10); s++) begin
        csn_in  = 1'b0;
        wrn_in  = 1'b0;
        addr_in = {2'(b), 4'(s)};
        #1;
        n_checks++;
        if ({csn_o, wrn_o, addr_o} !== {~(4'b0001 << b), 1'b0, 4'(s)})
          $display("FAIL update_route addr=%h csn/wrn/addr=%h/%b/%h expected=%h/0/%h",
                   addr_in, csn_o, wrn_o, addr_o, ~(4'b0001 << b), 4'(s));
        else n_pass++;
        tick();
      end
    end
    csn_in = 1'b1;
    wrn_in = 1'b1;
    n_checks++;
    if (addr_err !== 1'b0) $display("FAIL update_no_err err=%b expected=0", addr_err);
    else n_pass++;

    csn_in  = 1'b0;
    wrn_in  = 1'b0;
    addr_in = 6'h0A;
    #1;
    n_checks++;
    if (csn_o !== 4'hF) $display("FAIL bad_0A_csn csn=%h expected=F", csn_o);
    else n_pass++;
    tick();
    n_checks++;
    if (addr_err !== 1'b1) $display("FAIL bad_0A_err err=%b expected=1", addr_err);
    else n_pass++;
    addr_in = 6'h33;
    #1;
    n_checks++;
    if (csn_o !== 4'hF) $display("FAIL bad_33_csn csn=%h expected=F", csn_o);
    else n_pass++;
    tick();
    csn_in  = 1'b1;
    wrn_in  = 1'b1;
    addr_in = 6'h00;

    flag = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (addr_err !== 1'b1) $display("FAIL err_sticky err=%b expected=1", addr_err);
    else n_pass++;
    flag = 1'b1;
    tick();
    n_checks++;
    if (addr_err !== 1'b0) $display("FAIL err_clear_reentry err=%b expected=0", addr_err);
    else n_pass++;
    flag = 1'b0;
    tick();
  endtask

  task automatic test_overrun;
    start_seq();
    for (int k = 1; k <= 19; k++) begin
      if (k > 1) tick();
      if (k == 5) strobe = 1'b0;
      n_checks++;
      if (obs !== exp_vec(k))
        $display("FAIL overrun_seq k=%0d outputs=%h expected=%h", k, obs, exp_vec(k));
      else n_pass++;
      if (k == 4) strobe = 1'b1;
    end
    n_checks++;
    if (overrun !== EXP_OVR) $display("FAIL overrun_flag ovr=%b expected=%b", overrun, EXP_OVR);
    else n_pass++;
  endtask

  task automatic test_flag_mid;
    start_seq();
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs !== exp_vec(k))
        $display("FAIL flag_mid k=%0d outputs=%h expected=%h", k, obs, exp_vec(k));
      else n_pass++;
      if (k == 5) flag = 1'b1;
    end
    tick();
    csn_in  = 1'b0;
    addr_in = 6'h10;
    #1;
    n_checks++;
    if ({csn_o, wrn_o, addr_o, busy} !== {4'hD, 1'b1, 4'h0, 1'b0})
      $display("FAIL flag_mid_update csn/wrn/addr/busy=%h/%b/%h/%b expected=D/1/0/0",
               csn_o, wrn_o, addr_o, busy);
    else n_pass++;
    csn_in  = 1'b1;
    addr_in = 6'h00;
    for (int i = 0; i < 3; i++) begin
      strobe = 1'b1;
      tick();
      strobe = 1'b0;
      n_checks++;
      if ({busy, en_delay} !== 2'b00)
        $display("FAIL update_strobe_ignored i=%0d busy/delay=%b%b expected=00", i, busy, en_delay);
      else n_pass++;
    end
    flag = 1'b0;
    tick();
    n_checks++;
    if (obs !== IDLE_VEC) $display("FAIL flag_mid_wait outputs=%h expected=%h", obs, IDLE_VEC);
    else n_pass++;
  endtask

  task automatic test_reset_mid;
    start_seq();
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) tick();
      n_checks++;
      if (obs !== exp_vec(k))
        $display("FAIL reset_mid_seq k=%0d outputs=%h expected=%h", k, obs, exp_vec(k));
      else n_pass++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== IDLE_VEC || addr_err !== 1'b0 || overrun !== 1'b0)
      $display("FAIL reset_mid_async outputs=%h err=%b ovr=%b expected=%h 0 0",
               obs, addr_err, overrun, IDLE_VEC);
    else n_pass++;
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (obs !== IDLE_VEC)
        $display("FAIL reset_mid_quiet i=%0d outputs=%h expected=%h", i, obs, IDLE_VEC);
      else n_pass++;
    end
    run_seq("after_reset");
  endtask

  initial begin
    test_reset();
    test_filter();
    test_update();
    test_overrun();
    test_flag_mid();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_checks, n_pass);
    $fatal(1, "watchdog");
  end

endmodule
